lsu_align_unit: RTL and testbench
=================================

# lsu_align_unit

Load/store alignment unit sitting between the MEM pipeline stage and the data memory. It turns every byte, halfword and word access into word-aligned memory transactions with byte enables. Accesses that cross a 32-bit word boundary are split into two sequential transactions, with the pipeline held via a ready handshake. Load data is extracted, merged and sign- or zero-extended locally. The memory is always driven with word-format requests.

## Interface
- XLEN, 32, data width (from riscv_pkg)
- ALEN, 32, address width (from riscv_pkg)

- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- req_valid  in  1  MEM-stage access request; held stable until req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  LB/LH/LW/LBU/LHU (000/001/010/100/101); SB/SH/SW (000/001/010)
- req_addr  in  ALEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- req_ready  out  1  request completes this cycle; pipeline may advance
- rsp_valid  out  1  load result valid (1-cycle pulse, coincides with req_ready)
- rsp_rdata  out  XLEN  extended load result
- misaligned  out  1  1-cycle pulse when a split access is accepted
- mem_write  out  1  to data memory MemWrite
- mem_be  out  4  to data memory byte enable
- mem_funct3  out  3  constant 3'b010 (word); memory returns raw words
- mem_addr  out  ALEN  word-aligned address, bits [1:0] = 00
- mem_wdata  out  XLEN  byte-lane-positioned store data
- mem_rdata  in  XLEN  raw word; valid the cycle after mem_addr is presented

## Operation
- Size mask: byte = 0001, half = 0011, word (and undefined funct3) = 1111. off = addr[1:0].
- be64 = mask << off. wd64 = {32'b0, wdata} << (8*off).
- An access is split iff be64[7:4] != 0. Halfword at off 1 and byte at any offset are never split.
- Lo word address A = {addr[ALEN-1:2], 00}. Hi word address = A + 4, modulo 2^ALEN (0xFFFFFFFC wraps to 0x0).
- On acceptance in IDLE, the block captures funct3, off, be64, wd64 and A into registers. Later states use only the captured values.
- FSM states: IDLE, ST_HI, LD_WAIT, LD_HI, LD_HI_WAIT.
- IDLE, req_valid = 0: all mem_* outputs are 0 except mem_funct3.
- IDLE, store, not split: mem_write = 1, be = be64[3:0], wdata = wd64[31:0], addr = A, req_ready = 1. Stay in IDLE.
- IDLE, store, split: lo write as above, misaligned = 1, go to ST_HI.
- ST_HI: mem_write = 1, be = be64[7:4], wdata = wd64[63:32], addr = A + 4, req_ready = 1. Go to IDLE.
- IDLE, load: mem_write = 0, be = 0000, addr = A. Not split → LD_WAIT; split → misaligned = 1, go to LD_HI.
- LD_WAIT: rsp_valid = req_ready = 1. Result = extract({32'b0, mem_rdata}). Go to IDLE. No new access is issued in this cycle.
- LD_HI: latch lo_buf ← mem_rdata, issue read at A + 4. Go to LD_HI_WAIT.
- LD_HI_WAIT: rsp_valid = req_ready = 1. Result = extract({mem_rdata, lo_buf}). Go to IDLE.
- extract(w64):
  - s = w64 >> (8*off)
  - LB / LH: sign-extend s[7:0] / s[15:0]
  - LBU / LHU: zero-extend s[7:0] / s[15:0]
  - LW and undefined funct3: s[31:0]
- req_valid dropping mid-sequence is ignored; the sequence runs to completion.
- rsp_rdata holds its last value when rsp_valid = 0.

## Timing
- Aligned store: 1 cycle (req_ready in the accept cycle). Split store: 2 cycles.
- Aligned load: 2 cycles (rsp in the cycle after accept). Split load: 3 cycles.
- Back-to-back: a new request can be accepted in the cycle after req_ready.
- Outputs in IDLE are combinational from req_*. Outputs in all other states are driven from registers and state.
- Reset asserted asynchronously:
  - state → IDLE
  - lo_buf, rsp_rdata and captured fields → 0
  - mem_write, mem_be, req_ready, rsp_valid, misaligned → 0 immediately, including mid-split
  - a partially completed split store is not rolled back
- Reset release: the first request can be accepted on the first clk edge with rst = 0.

## Test plan
- SW 0x11223344 @ 0x100 → single cycle: mem_addr 0x100, be 1111, wdata 0x11223344, req_ready = 1, misaligned = 0.
- SW 0xAABBCCDD @ 0x102 → two cycles:
  - cycle 1: addr 0x100, be 1100, wdata 0xCCDD0000, misaligned = 1
  - cycle 2: addr 0x104, be 0011, wdata 0x0000AABB, req_ready = 1
- LW @ 0x102 after the previous store → reads 0x100 then 0x104; rsp_valid on cycle 3 with rsp_rdata = 0xAABBCCDD.
- Memory 0x100 = 0xF0000000, 0x104 = 0x000000A5 → LH @ 0x103 gives 0xFFFFA5F0; LHU @ 0x103 gives 0x0000A5F0; LB @ 0x103 gives 0xFFFFFFF0; LH @ 0x101 is not split and gives 0x00000000.
- LW @ 0xFFFFFFFE → hi read addresses 0x00000000 (wrap); combined result is correct.
- rst pulsed during ST_HI of a split store → mem_write drops immediately, no hi write is issued, state is IDLE. The next aligned SW completes in 1 cycle.

Source files
------------

// File: rtl/lsu_align_unit.sv
// lsu_align_unit: splits byte/half/word loads and stores into word-aligned memory
// transactions with byte enables, and extracts and extends the load data.
module lsu_align_unit #(
    parameter int XLEN = 32,
    parameter int ALEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [ALEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            misaligned,
    output logic            mem_write,
    output logic [3:0]      mem_be,
    output logic [2:0]      mem_funct3,
    output logic [ALEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, ST_HI, LD_WAIT, LD_HI, LD_HI_WAIT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [7:0]        be64_q, be64_d;
    logic [2*XLEN-1:0] wd64_q, wd64_d;
    logic [ALEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   lo_buf_q, lo_buf_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [3:0]        mask_in;
    logic [7:0]        be64_in;
    logic [2*XLEN-1:0] wd64_in;
    logic [ALEN-1:0]   a_in;
    logic              split_in;
    logic [XLEN-1:0]   ext;

    function automatic logic [XLEN-1:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [2*XLEN-1:0] w);
        logic [2*XLEN-1:0] s;
        s = w >> {off, 3'b000};
        return f3 == 3'b000 ? {{(XLEN-8){s[7]}}, s[7:0]} :
               f3 == 3'b001 ? {{(XLEN-16){s[15]}}, s[15:0]} :
               f3 == 3'b100 ? {{(XLEN-8){1'b0}}, s[7:0]} :
               f3 == 3'b101 ? {{(XLEN-16){1'b0}}, s[15:0]} : s[XLEN-1:0];
    endfunction

    // funct3[1:0] alone selects the size: 00 byte, 01 half, anything else a full word
    assign mask_in    = req_funct3[1:0] == 2'b00 ? 4'b0001 :
                        req_funct3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    assign be64_in    = {4'b0000, mask_in} << req_addr[1:0];
    assign wd64_in    = {{XLEN{1'b0}}, req_wdata} << {req_addr[1:0], 3'b000};
    assign a_in       = {req_addr[ALEN-1:2], 2'b00};
    assign split_in   = |be64_in[7:4];
    assign mem_funct3 = 3'b010;
    assign rsp_rdata  = rsp_valid ? ext : rsp_rdata_q;

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        be64_d      = be64_q;
        wd64_d      = wd64_q;
        a_d         = a_q;
        lo_buf_d    = lo_buf_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        misaligned  = 1'b0;
        mem_write   = 1'b0;
        mem_be      = 4'b0000;
        mem_addr    = '0;
        mem_wdata   = '0;
        ext         = '0;
        case (state_q)
            IDLE: begin
                // rst gates the combinational accept path so outputs drop during reset
                if (req_valid && !rst) begin
                    funct3_d   = req_funct3;
                    off_d      = req_addr[1:0];
                    be64_d     = be64_in;
                    wd64_d     = wd64_in;
                    a_d        = a_in;
                    mem_write  = req_write;
                    mem_addr   = a_in;
                    mem_be     = req_write ? be64_in[3:0] : 4'b0000;
                    mem_wdata  = req_write ? wd64_in[XLEN-1:0] : '0;
                    misaligned = split_in;
                    req_ready  = req_write && !split_in;
                    state_d    = req_write ? (split_in ? ST_HI : IDLE) : (split_in ? LD_HI : LD_WAIT);
                end
            end
            ST_HI: begin
                mem_write = 1'b1;
                mem_be    = be64_q[7:4];
                mem_wdata = wd64_q[2*XLEN-1:XLEN];
                mem_addr  = a_q + ALEN'(4);
                req_ready = 1'b1;
                state_d   = IDLE;
            end
            LD_WAIT: begin
                rsp_valid = 1'b1;
                req_ready = 1'b1;
                ext       = extract(funct3_q, off_q, {{XLEN{1'b0}}, mem_rdata});
                state_d   = IDLE;
            end
            LD_HI: begin
                lo_buf_d = mem_rdata;
                mem_addr = a_q + ALEN'(4);
                state_d  = LD_HI_WAIT;
            end
            LD_HI_WAIT: begin
                rsp_valid = 1'b1;
                req_ready = 1'b1;
                ext       = extract(funct3_q, off_q, {mem_rdata, lo_buf_q});
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rsp_rdata_d = rsp_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            funct3_q    <= '0;
            off_q       <= '0;
            be64_q      <= '0;
            wd64_q      <= '0;
            a_q         <= '0;
            lo_buf_q    <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            be64_q      <= be64_d;
            wd64_q      <= wd64_d;
            a_q         <= a_d;
            lo_buf_q    <= lo_buf_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end
endmodule

// File: tb/tb_lsu_align_unit.sv
// tb_lsu_align_unit: directed load/store vectors against a byte-enabled memory model,
// with write transactions and load responses checked by a queue-based monitor.
module tb_lsu_align_unit;
    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b010;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, misaligned, mem_write;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  mem_be;
    logic [2:0]  mem_funct3;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_w, wr_w;
    wr_t         wq[$];
    logic [31:0] rq[$];
    int          n_vec = 0;
    int          n_bad = 0;

    lsu_align_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .misaligned(misaligned), .mem_write(mem_write), .mem_be(mem_be),
        .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_w = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        if (mem_write) begin
            wr_w = rd_w;
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) wr_w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr] = wr_w;
        end
        mem_rdata <= rd_w;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        logic [31:0] r;
        if (mem_write) begin
            if (wq.size() == 0) chk("wr_unexpected_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                e = wq.pop_front();
                chk("wr_addr", mem_addr, e.a);
                chk("wr_be", mem_be, e.be);
                chk("wr_data", mem_wdata, e.d);
            end
        end
        if (rsp_valid) begin
            if (rq.size() == 0) chk("rsp_unexpected", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                r = rq.pop_front();
                chk("rsp_rdata", rsp_rdata, r);
            end
        end
    end

    task automatic exp_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_t e;
        e.a = a; e.be = be; e.d = d;
        wq.push_back(e);
    endtask

    // Drives one request just after a posedge and holds it until req_ready.
    task automatic op(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input int ecyc, input int emis);
        int cyc = 0;
        int mis = 0;
        bit done = 0;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
            mis += int'(misaligned);
            if (req_ready) done = 1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("latency", done ? cyc : 99, ecyc);
        chk("misaligned_pulses", mis, emis);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp,
                      input int ecyc, input int emis);
        rq.push_back(exp);
        op(1'b0, f3, addr, 32'h0, ecyc, emis);
    endtask

    initial begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h102;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("mem_funct3", mem_funct3, 3'b010);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_mem_be", mem_be, 0);
        chk("idle_mem_addr", mem_addr, 0);
        @(posedge clk);
        #1;

        exp_wr(32'h100, 4'hF, 32'h11223344);
        op(1'b1, 3'b010, 32'h100, 32'h11223344, 1, 0);
        exp_wr(32'h100, 4'hC, 32'hCCDD0000);
        exp_wr(32'h104, 4'h3, 32'h0000AABB);
        op(1'b1, 3'b010, 32'h102, 32'hAABBCCDD, 2, 1);
        ld(3'b010, 32'h102, 32'hAABBCCDD, 3, 1);

        exp_wr(32'h100, 4'hF, 32'hF0000000);
        op(1'b1, 3'b010, 32'h100, 32'hF0000000, 1, 0);
        exp_wr(32'h104, 4'hF, 32'h000000A5);
        op(1'b1, 3'b010, 32'h104, 32'h000000A5, 1, 0);
        ld(3'b001, 32'h103, 32'hFFFFA5F0, 3, 1);
        ld(3'b101, 32'h103, 32'h0000A5F0, 3, 1);
        ld(3'b000, 32'h103, 32'hFFFFFFF0, 2, 0);
        ld(3'b001, 32'h101, 32'h00000000, 2, 0);
        ld(3'b100, 32'h103, 32'h000000F0, 2, 0);
        @(negedge clk);
        chk("rsp_hold_valid", rsp_valid, 0);
        chk("rsp_hold_rdata", rsp_rdata, 32'h000000F0);
        @(posedge clk);
        #1;

        exp_wr(32'h200, 4'h2, 32'h0000EE00);
        op(1'b1, 3'b000, 32'h201, 32'h000000EE, 1, 0);
        exp_wr(32'h200, 4'h8, 32'hEF000000);
        exp_wr(32'h204, 4'h1, 32'h000000BE);
        op(1'b1, 3'b001, 32'h203, 32'h0000BEEF, 2, 1);
        ld(3'b010, 32'h200, 32'hEF00EE00, 2, 0);
        ld(3'b100, 32'h204, 32'h000000BE, 2, 0);

        exp_wr(32'hFFFFFFFC, 4'hF, 32'h12345678);
        op(1'b1, 3'b010, 32'hFFFFFFFC, 32'h12345678, 1, 0);
        exp_wr(32'h00000000, 4'hF, 32'h9ABCDEF0);
        op(1'b1, 3'b010, 32'h00000000, 32'h9ABCDEF0, 1, 0);
        ld(3'b010, 32'hFFFFFFFE, 32'hDEF01234, 3, 1);

        exp_wr(32'h300, 4'hC, 32'hCCDD0000);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h302; req_wdata = 32'hAABBCCDD;
        @(negedge clk);
        chk("split_accept_mis", misaligned, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("st_hi_write", mem_write, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_write", mem_write, 0);
        chk("rst_mid_mem_be", mem_be, 0);
        chk("rst_mid_req_ready", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("no_hi_write", mem.exists(32'h304), 0);
        exp_wr(32'h300, 4'hF, 32'h55667788);
        op(1'b1, 3'b010, 32'h300, 32'h55667788, 1, 0);
        ld(3'b010, 32'h300, 32'h55667788, 2, 0);

        repeat (3) @(posedge clk);
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
